codec_serial_tx: RTL and testbench
==================================

// Module: codec_serial_tx
// PURPOSE
//  Codec-side transmitter for the audio path: takes filtered stereo samples (parallel, 2's complement).
//  Generates the codec master clocks (mclk, sclk, lrck).
//  Shifts samples out MSB-first on sdout in I2S format (one-bit delay after lrck edge).
//  Sits between the filter output and the codec DAC pins; a one-entry buffer decouples filter and frame timing.
// PARAMETERS
//  SAMPLE_WIDTH  20  bits per channel sample, 2's complement, sent unmodified
//  SLOT_WIDTH    32  sclk periods per channel slot; must be >= SAMPLE_WIDTH+1
//  SCLK_HALF     4   clk cycles per sclk half-period (sclk period = 8 clk)
//  MCLK_HALF     1   clk cycles per mclk half-period (mclk = clk/2)
// PORTS
//  clk       in   1                  system clock, all logic on posedge
//  reset     in   1                  reset, synchronous, active-high
//  in_valid  in   1                  stereo sample pair offered
//  in_ready  out  1                  buffer can accept; transfer when in_valid && in_ready
//  in_left   in   SAMPLE_WIDTH       left sample
//  in_right  in   SAMPLE_WIDTH       right sample
//  mclk      out  1                  codec master clock
//  sclk      out  1                  bit clock; codec samples sdout on sclk rising edge
//  lrck      out  1                  0 = left slot, 1 = right slot
//  sdout     out  1                  serial data to codec
//  seq       out  clog2(2*SLOT_WIDTH)  current bit position in frame (0..2*SLOT_WIDTH-1)
//  underrun  out  1                  sticky: a frame started with no sample available
// BEHAVIOUR
//  Reset (any cycle, including mid-frame):
//   - mclk=sclk=lrck=sdout=0; underrun=0.
//   - Buffer emptied (in_ready=1 the next cycle); shift regs cleared.
//   - seq=2*SLOT_WIDTH-1, so the first sclk falling edge is a frame start.
//  Clocks:
//   - mclk toggles every MCLK_HALF clks.
//   - sclk toggles every SCLK_HALF clks.
//   - "fall" strobe = clk cycle in which sclk goes 1->0.
//  On each fall:
//   - seq increments, wrapping 2*SLOT_WIDTH-1 -> 0.
//   - lrck = (new seq >= SLOT_WIDTH).
//   - sdout = bit selected by new seq; sdout, lrck and seq change in the same cycle.
//  Bit map: seq 1..SAMPLE_WIDTH -> left[MSB..LSB]; seq SLOT_WIDTH+1..SLOT_WIDTH+SAMPLE_WIDTH -> right[MSB..LSB].
//   All other positions (incl. 0 and SLOT_WIDTH) drive 0.
//  Frame start = fall with seq wrapping to 0. Shift regs load:
//   - Buffer full: load from buffer; buffer becomes empty; in_ready=1 next cycle.
//   - Buffer empty, in_valid=1 same cycle: bypass input straight to shift regs; no underrun.
//   - Buffer empty, no input: load zeros, set underrun (cleared only by reset).
//  Accept: in_ready = buffer empty. Accept writes the buffer on that clk edge.
//   - Accept is suppressed into the buffer when bypass occurs.
//   - Buffer is never overwritten while full.
//  Latency: sample accepted mid-frame -> loaded at next frame start; left MSB on sdout 1 sclk period after lrck falls.
// STRUCTURE
//  codec_pkg:
//   - SAMPLE_WIDTH / SLOT_WIDTH defaults.
//   - stereo_sample_t {left, right}.
//   - Function computing seq width.
//  Sub-module codec_clk_gen:
//   - mclk/sclk dividers and fall strobe.
//  Top: buffer, seq counter, lrck, shift/select, underrun.
// TESTING
//  1 Reset: hold 3 clks -> mclk=sclk=lrck=sdout=underrun=0, in_ready=1; sclk period 8 clk, mclk period 2 clk after release.
//  2 Serial format: accept L=20'hA5A5A, R=20'h12345 -> next frame:
//    - lrck=0 for seq 0..31; sdout seq1..20 = A5A5A MSB-first; seq 21..31 = 0.
//    - lrck=1 seq 32..63; seq33..52 = 12345.
//  3 Underrun: no input for one frame -> sdout all 0 for 64 bits, underrun=1 and stays 1 after later valid frames.
//  4 Backpressure: offer 3 pairs back-to-back mid-frame:
//    - first accepted, in_ready=0 until frame start.
//    - second accepted the cycle after load.
//    - third accepted one frame later; order preserved.
//  5 Bypass: empty buffer, in_valid asserted only on frame-start cycle with L=20'h80000 -> sdout seq1=1, seq2..20=0, underrun stays 0.
//  6 Reset mid-frame: buffer full, reset at seq=10 -> next cycle all outputs 0, in_ready=1; buffered pair never transmitted.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared defaults and helpers for the codec audio output path.
package codec_pkg;

  localparam int unsigned SAMPLE_WIDTH = 20;
  localparam int unsigned SLOT_WIDTH   = 32;
  localparam int unsigned SCLK_HALF    = 4;
  localparam int unsigned MCLK_HALF    = 1;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } stereo_sample_t;

  // Width of the in-frame bit position counter (two slots per frame).
  function automatic int unsigned seq_width(input int unsigned slot_width);
    return $clog2(2 * slot_width);
  endfunction

endpackage

// File: rtl/codec_clk_gen.sv
// Codec master clock and bit clock dividers; flags the clk cycle in which sclk falls.
module codec_clk_gen #(
  parameter int unsigned SCLK_HALF = 4,
  parameter int unsigned MCLK_HALF = 1
) (
  input  logic clk,
  input  logic reset,
  output logic mclk,
  output logic sclk,
  output logic sclk_fall
);

  localparam int unsigned SCNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned MCNT_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SCLK_HALF - 1);
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MCLK_HALF - 1);

  logic [SCNT_W-1:0] sclk_cnt;
  logic [MCNT_W-1:0] mclk_cnt;
  logic              sclk_wrap;
  logic              mclk_wrap;

  assign sclk_wrap = (sclk_cnt == SCNT_LAST);
  assign mclk_wrap = (mclk_cnt == MCNT_LAST);
  // Strobe is asserted in the cycle whose edge drives sclk from 1 to 0.
  assign sclk_fall = sclk_wrap & sclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_cnt <= '0;
      sclk     <= 1'b0;
    end else if (sclk_wrap) begin
      sclk_cnt <= '0;
      sclk     <= ~sclk;
    end else begin
      sclk_cnt <= sclk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mclk_cnt <= '0;
      mclk     <= 1'b0;
    end else if (mclk_wrap) begin
      mclk_cnt <= '0;
      mclk     <= ~mclk;
    end else begin
      mclk_cnt <= mclk_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/codec_serial_tx.sv
// I2S transmitter: one-entry sample buffer, frame position counter and MSB-first
// serialiser driving the codec DAC pins.
module codec_serial_tx
  import codec_pkg::*;
#(
  parameter  int unsigned SAMPLE_WIDTH = codec_pkg::SAMPLE_WIDTH,
  parameter  int unsigned SLOT_WIDTH   = codec_pkg::SLOT_WIDTH,
  parameter  int unsigned SCLK_HALF    = codec_pkg::SCLK_HALF,
  parameter  int unsigned MCLK_HALF    = codec_pkg::MCLK_HALF,
  localparam int unsigned SEQ_W        = seq_width(SLOT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  output logic                    mclk,
  output logic                    sclk,
  output logic                    lrck,
  output logic                    sdout,
  output logic [SEQ_W-1:0]        seq,
  output logic                    underrun
);

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] left;
    logic [SAMPLE_WIDTH-1:0] right;
  } pair_t;

  localparam logic [SEQ_W-1:0] SEQ_LAST    = SEQ_W'(2 * SLOT_WIDTH - 1);
  localparam logic [SEQ_W-1:0] SLOT_START  = SEQ_W'(SLOT_WIDTH);
  localparam logic [SEQ_W-1:0] LEFT_LAST   = SEQ_W'(SAMPLE_WIDTH);
  localparam logic [SEQ_W-1:0] RIGHT_FIRST = SEQ_W'(SLOT_WIDTH + 1);
  localparam logic [SEQ_W-1:0] RIGHT_LAST  = SEQ_W'(SLOT_WIDTH + SAMPLE_WIDTH);

  logic                    sclk_fall;
  logic                    buf_full;
  pair_t                   buf_pair;
  pair_t                   in_pair;
  pair_t                   load_pair;
  logic [SAMPLE_WIDTH-1:0] sh_left;
  logic [SAMPLE_WIDTH-1:0] sh_right;
  logic [SEQ_W-1:0]        seq_next;
  logic                    frame_start;
  logic                    accept;
  logic                    bypass;
  logic                    left_bit;
  logic                    right_bit;

  codec_clk_gen #(
    .SCLK_HALF(SCLK_HALF),
    .MCLK_HALF(MCLK_HALF)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .mclk     (mclk),
    .sclk     (sclk),
    .sclk_fall(sclk_fall)
  );

  assign in_ready = ~buf_full;

  always_comb begin
    in_pair     = '{left: in_left, right: in_right};
    seq_next    = (seq == SEQ_LAST) ? '0 : seq + 1'b1;
    frame_start = sclk_fall && (seq == SEQ_LAST);
    accept      = in_valid && !buf_full;
    // An empty buffer at frame start lets the offered pair skip straight to the shifters.
    bypass      = frame_start && !buf_full && in_valid;
    left_bit    = (seq_next != '0) && (seq_next <= LEFT_LAST);
    right_bit   = (seq_next >= RIGHT_FIRST) && (seq_next <= RIGHT_LAST);
    if (buf_full) begin
      load_pair = buf_pair;
    end else if (in_valid) begin
      load_pair = in_pair;
    end else begin
      load_pair = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_pair <= '0;
    end else if (frame_start && buf_full) begin
      buf_full <= 1'b0;
    end else if (accept && !bypass) begin
      buf_full <= 1'b1;
      buf_pair <= in_pair;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq      <= SEQ_LAST;
      lrck     <= 1'b0;
      sdout    <= 1'b0;
      sh_left  <= '0;
      sh_right <= '0;
      underrun <= 1'b0;
    end else if (sclk_fall) begin
      seq  <= seq_next;
      lrck <= (seq_next >= SLOT_START);
      if (frame_start) begin
        sh_left  <= load_pair.left;
        sh_right <= load_pair.right;
        sdout    <= 1'b0;
        if (!buf_full && !in_valid) begin
          underrun <= 1'b1;
        end
      end else if (left_bit) begin
        sdout   <= sh_left[SAMPLE_WIDTH-1];
        sh_left <= sh_left << 1;
      end else if (right_bit) begin
        sdout    <= sh_right[SAMPLE_WIDTH-1];
        sh_right <= sh_right << 1;
      end else begin
        sdout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_codec_serial_tx.sv
// Directed bench for codec_serial_tx: clocks, I2S framing, buffering, bypass, underrun, reset.
module tb_codec_serial_tx;

  localparam int SW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_left;
  logic [SW-1:0] in_right;
  logic          mclk;
  logic          sclk;
  logic          lrck;
  logic          sdout;
  logic [5:0]    seq;
  logic          underrun;

  codec_serial_tx #(
    .SAMPLE_WIDTH(20),
    .SLOT_WIDTH  (32),
    .SCLK_HALF   (4),
    .MCLK_HALF   (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_left (in_left),
    .in_right(in_right),
    .mclk    (mclk),
    .sclk    (sclk),
    .lrck    (lrck),
    .sdout   (sdout),
    .seq     (seq),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned base;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After return, edge E0 is the last reset edge and cyc-base counts edges since.
  task automatic do_reset(input int n);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
    base  = cyc;
  endtask

  // Captures the next complete frame (seq 0..63) and checks lrck along the way.
  task automatic get_frame(input string tag, output logic [SW-1:0] l, output logic [SW-1:0] r,
                           output logic pad);
    logic [63:0] fb;
    int prev;
    int lrck_err;
    bit started;
    bit done;
    fb = '0;
    lrck_err = 0;
    started = 0;
    done = 0;
    prev = int'(seq);
    for (int t = 0; t < 1200 && !done; t++) begin
      tick();
      if (int'(seq) != prev) begin
        prev = int'(seq);
        if (seq == 6'd0) started = 1;
        if (started) begin
          fb[seq] = sdout;
          if (lrck !== (seq >= 6'd32)) lrck_err++;
          if (seq == 6'd63) done = 1;
        end
      end
    end
    check({tag, "_complete"}, 32'(done), 32'd1);
    check({tag, "_lrck"}, 32'(lrck_err), 32'd0);
    l = '0;
    r = '0;
    pad = 1'b0;
    for (int i = 0; i < SW; i++) begin
      l[SW-1-i] = fb[1+i];
      r[SW-1-i] = fb[33+i];
    end
    for (int p = 0; p < 64; p++) begin
      if (!((p >= 1 && p <= 20) || (p >= 33 && p <= 52))) pad |= fb[p];
    end
  endtask

  logic [SW-1:0] fl, fr;
  logic          fpad;
  logic [SW-1:0] pl[3];
  logic [SW-1:0] pr[3];
  int unsigned   acc[3];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;

    // Reset state and clock timing
    do_reset(3);
    check("rst_mclk", mclk, 0);
    check("rst_sclk", sclk, 0);
    check("rst_lrck", lrck, 0);
    check("rst_sdout", sdout, 0);
    check("rst_underrun", underrun, 0);
    check("rst_ready", in_ready, 1);
    check("rst_seq", seq, 63);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("clk_mclk", mclk, 32'(k % 2));
      check("clk_sclk", sclk, 32'((k / 4) % 2));
      if (k == 7) check("pre_start_underrun", underrun, 0);
      if (k == 8) begin
        check("first_fall_seq", seq, 0);
        check("empty_start_underrun", underrun, 1);
      end
    end

    // Serial format
    do_reset(2);
    in_valid = 1'b1;
    in_left  = 20'hA5A5A;
    in_right = 20'h12345;
    tick();
    in_valid = 1'b0;
    check("fmt_ready_after_accept", in_ready, 0);
    get_frame("fmt", fl, fr, fpad);
    check("fmt_left", fl, 20'hA5A5A);
    check("fmt_right", fr, 20'h12345);
    check("fmt_pad", fpad, 0);
    check("fmt_underrun", underrun, 0);

    // Bypass on the frame-start cycle
    do_reset(2);
    fork
      begin
        repeat (7) tick();
        check("byp_ready_before", in_ready, 1);
        in_valid = 1'b1;
        in_left  = 20'h80000;
        in_right = 20'h00001;
        tick();
        in_valid = 1'b0;
        check("byp_seq", seq, 0);
        check("byp_ready_after", in_ready, 1);
      end
      get_frame("byp", fl, fr, fpad);
    join
    check("byp_left", fl, 20'h80000);
    check("byp_right", fr, 20'h00001);
    check("byp_pad", fpad, 0);
    check("byp_underrun", underrun, 0);

    // Backpressure: three pairs offered back to back
    pl[0] = 20'h00001; pr[0] = 20'hFFFFF;
    pl[1] = 20'h7FFFF; pr[1] = 20'h80000;
    pl[2] = 20'hC3C3C; pr[2] = 20'h3C3C3;
    do_reset(2);
    fork
      begin
        int i;
        logic rdy;
        i = 0;
        in_valid = 1'b1;
        in_left  = pl[0];
        in_right = pr[0];
        for (int t = 0; t < 2000 && i < 3; t++) begin
          rdy = in_ready;
          if (cyc - base == 7) check("bp_ready_held", in_ready, 0);
          tick();
          if (rdy) begin
            acc[i] = cyc - base;
            i++;
            if (i < 3) begin
              in_left  = pl[i];
              in_right = pr[i];
            end else begin
              in_valid = 1'b0;
            end
          end
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 32'(i), 3);
      end
      begin
        for (int f = 0; f < 3; f++) begin
          get_frame("bp", fl, fr, fpad);
          check("bp_left", fl, pl[f]);
          check("bp_right", fr, pr[f]);
          check("bp_pad", fpad, 0);
          check("bp_underrun", underrun, 0);
        end
      end
    join
    check("bp_acc0_cycle", acc[0], 1);
    check("bp_acc1_cycle", acc[1], 9);
    check("bp_acc2_cycle", acc[2], 521);

    // Underrun: nothing offered for a whole frame, then valid data again
    get_frame("ur", fl, fr, fpad);
    check("ur_left", fl, 0);
    check("ur_right", fr, 0);
    check("ur_pad", fpad, 0);
    check("ur_flag", underrun, 1);
    in_valid = 1'b1;
    in_left  = 20'h0F0F0;
    in_right = 20'hFEDCB;
    tick();
    in_valid = 1'b0;
    get_frame("ur_after", fl, fr, fpad);
    check("ur_after_left", fl, 20'h0F0F0);
    check("ur_after_right", fr, 20'hFEDCB);
    check("ur_sticky", underrun, 1);

    // Reset mid-frame with a full buffer
    do_reset(2);
    in_valid = 1'b1;
    in_left  = 20'h55555;
    in_right = 20'hAAAAA;
    tick();
    in_left  = 20'hFFFFF;
    in_right = 20'hFFFFF;
    begin
      bit got;
      got = 0;
      for (int t = 0; t < 50 && !got; t++) begin
        got = in_ready;
        tick();
      end
      check("mr_second_accepted", 32'(got), 1);
    end
    in_valid = 1'b0;
    begin
      bit hit;
      hit = 0;
      for (int t = 0; t < 200 && !hit; t++) begin
        tick();
        if (seq == 6'd10) hit = 1;
      end
      check("mr_reached_seq10", 32'(hit), 1);
    end
    check("mr_buf_full", in_ready, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_mclk", mclk, 0);
    check("mr_sclk", sclk, 0);
    check("mr_lrck", lrck, 0);
    check("mr_sdout", sdout, 0);
    check("mr_underrun", underrun, 0);
    check("mr_ready", in_ready, 1);
    check("mr_seq", seq, 63);
    get_frame("mr", fl, fr, fpad);
    check("mr_left", fl, 0);
    check("mr_right", fr, 0);
    check("mr_pad", fpad, 0);
    check("mr_underrun_after", underrun, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
